fsub_serial: RTL and testbench
==============================

Name: fsub_serial

Overview:
Bit-serial subtractor, the inverse of the team's 4-bit full-adder block. It computes d = a - b - bin over WIDTH bits, one bit per clock, LSB first, through a single full-subtractor cell. A start/ready/done handshake lets a controller or testbench drive it. Results are held stable until the next operation is accepted.

Parameters:
WIDTH, 4, operand/result width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted on a clk edge where start=1 and ready=1
a  input  WIDTH  minuend; sampled only on accept
b  input  WIDTH  subtrahend; sampled only on accept
bin  input  1  borrow-in; sampled only on accept
ready  output  1  1 when an operation can be accepted (IDLE or DONE)
busy  output  1  1 while bits are being processed (SHIFT)
d  output  WIDTH  difference, valid from done onward
bout  output  1  borrow-out, valid from done onward
done  output  1  one-cycle pulse, result valid

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset, async on rst_n low:
  - state=IDLE, bit counter=0, internal operand/borrow registers=0.
  - d=0, bout=0, done=0, busy=0, ready=1.
  - Reset during SHIFT aborts the operation with no done pulse.
- FSM states:
  - IDLE: ready=1, busy=0, done=0. Go to SHIFT on accept.
  - SHIFT: ready=0, busy=1. Processes bit [cnt] on each edge; cnt goes 0..WIDTH-1. After processing bit WIDTH-1, go to DONE.
  - DONE: ready=1, busy=0, done=1 for exactly this one cycle. Next edge: SHIFT if start=1 (new accept), else IDLE.
- On accept:
  - Latch a, b, bin into internal registers.
  - Clear the d shift register.
  - Set cnt=0.
  - bout keeps its old value until the new result is written.
- Per-bit arithmetic (ai, bi, borrow br):
  - di = ai ^ bi ^ br
  - br_next = (~ai & bi) | (~(ai ^ bi) & br)
  - br starts at the latched bin.
- Result write: d[i]=di is written as each bit completes. bout = final br, written on the edge that enters DONE.
- Width rule: d = (a - b - bin) mod 2^WIDTH. bout=1 iff a < b + bin (unsigned compare).
- Latency: accept on edge E0; bits are processed on edges E1..E_WIDTH; done=1 in the cycle after E_WIDTH. For WIDTH=4, done is seen 4 edges after accept.
- Inputs changing after accept have no effect on the running operation.
- start while busy=1 is ignored; it is not queued.
- Back-to-back: start=1 during DONE is accepted, giving continuous throughput of one result per WIDTH+1 cycles.
- d and bout stay stable from DONE until the next result overwrites them (d is also cleared on accept).

Decomposition:
- Shared package fsub_pkg holds:
  - the state encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - the default WIDTH;
  - the counter width, defined as clog2(WIDTH).
- Sub-module fsub_bit: a combinational 1-bit full subtractor (ai, bi, br -> di, br_next). It is instantiated once inside fsub_serial.

Test Plan:
1. After reset: a=4'b0101, b=4'b0011, bin=0, pulse start -> busy high for 4 cycles, then done pulse with d=4'b0010, bout=0.
2. a=4'b0011, b=4'b0101, bin=0 -> d=4'b1110, bout=1. Also a=4'b0000, b=4'b0000, bin=1 -> d=4'b1111, bout=1 (full wrap).
3. During SHIFT, change a/b and assert start -> result still matches the latched operands; no extra operation starts; ready stays 0.
4. Hold start=1 with a new operand set during DONE -> a new operation is accepted immediately; the done pulses are 5 cycles apart and each carries the correct d and bout.
5. Pull rst_n low at cycle 2 of SHIFT -> d=0, bout=0, ready=1 immediately (asynchronous), and no done pulse follows.
6. Exhaustive sweep of all 512 combinations of a, b, bin -> every d and bout matches the reference arithmetic (a-b-bin mod 16, borrow on a<b+bin).

Source files
------------

// File: rtl/fsub_pkg.sv
// fsub_pkg: shared state encoding and sizing for the bit-serial subtractor
package fsub_pkg;
   localparam int WIDTH_DEF = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
   function automatic int cnt_w(input int w);
      return $clog2(w);
   endfunction
   localparam int CNT_W = cnt_w(WIDTH_DEF);
endpackage

// File: rtl/fsub_bit.sv
// fsub_bit: combinational 1-bit full subtractor
module fsub_bit (
   input  logic ai,
   input  logic bi,
   input  logic br,
   output logic di,
   output logic br_next
);
   assign di      = ai ^ bi ^ br;
   assign br_next = (~ai & bi) | (~(ai ^ bi) & br);
endmodule

// File: rtl/fsub_serial.sv
// fsub_serial: LSB-first bit-serial subtractor, d = a - b - bin, with start/ready/done handshake
module fsub_serial
   import fsub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic             busy,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             done
);
   localparam int CW = cnt_w(WIDTH);
   state_t           state, nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] ar, br_r;
   logic             brw, di, bnx, accept, last;
   assign accept = start & ready;
   assign last   = cnt == CW'(WIDTH - 1);
   fsub_bit u_bit (.ai(ar[cnt]), .bi(br_r[cnt]), .br(brw), .di(di), .br_next(bnx));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   always_comb
      nxt = state == SHIFT ? (last ? DONE : SHIFT) : (start ? SHIFT : IDLE);
   always_comb begin
      ready = state != SHIFT;
      busy  = state == SHIFT;
      done  = state == DONE;
   end
   // bout is only touched on the final bit, so it survives the accept of the next op
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ar   <= '0;
         br_r <= '0;
         brw  <= 1'b0;
         d    <= '0;
         bout <= 1'b0;
         cnt  <= '0;
      end else if (accept) begin
         ar   <= a;
         br_r <= b;
         brw  <= bin;
         d    <= '0;
         cnt  <= '0;
      end else if (busy) begin
         d[cnt] <= di;
         brw    <= bnx;
         cnt    <= cnt + CW'(1);
         if (last) bout <= bnx;
      end
endmodule

// File: tb/tb_fsub_serial.sv
// tb_fsub_serial: directed and exhaustive checks of the bit-serial subtractor
module tb_fsub_serial;
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, bin = 1'b0;
   logic [3:0] a = '0, b = '0, d;
   logic       ready, busy, bout, done;
   int         checks = 0, errors = 0, cyc = 0;

   fsub_serial #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .ready(ready), .busy(busy), .d(d), .bout(bout), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 12) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run(input string tag, input logic [3:0] ai, input logic [3:0] bi, input logic bi_n,
                      input logic [3:0] ed, input logic eb, input bit full);
      int n;
      @(negedge clk);
      a = ai; b = bi; bin = bi_n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (full) chk({tag, "_busy"}, busy, 1'b1);
      wait_done(n);
      if (full) chk({tag, "_lat"}, n, 4);
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_d"}, d, ed);
      chk({tag, "_bout"}, bout, eb);
   endtask

   initial begin
      int n, t1, t2, seen;
      logic [4:0] ref5;
      #12;
      chk("rst_ready", ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_d", d, 4'h0);
      chk("rst_bout", bout, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      run("t1", 4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b1);
      @(negedge clk);
      chk("t1_idle_ready", ready, 1'b1);
      chk("t1_idle_done", done, 1'b0);
      run("t2a", 4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b1);
      run("t2b", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b1);

      // Operand and start changes mid-operation must be ignored
      @(negedge clk);
      a = 4'b1001; b = 4'b0100; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 4'hf; b = 4'hf; bin = 1'b1;
      chk("t3_ready0", ready, 1'b0);
      @(negedge clk);
      chk("t3_ready1", ready, 1'b0);
      chk("t3_busy", busy, 1'b1);
      start = 1'b0;
      wait_done(n);
      chk("t3_done", done, 1'b1);
      chk("t3_d", d, 4'b0101);
      chk("t3_bout", bout, 1'b0);
      @(negedge clk);
      chk("t3_no_extra", busy, 1'b0);

      // Back-to-back accept during DONE
      a = 4'd7; b = 4'd2; bin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      t1 = cyc;
      chk("t4a_done", done, 1'b1);
      chk("t4a_d", d, 4'd4);
      chk("t4a_bout", bout, 1'b0);
      a = 4'd2; b = 4'd7; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t4_reaccept", busy, 1'b1);
      wait_done(n);
      t2 = cyc;
      chk("t4b_done", done, 1'b1);
      chk("t4_spacing", t2 - t1, 5);
      chk("t4b_d", d, 4'b1011);
      chk("t4b_bout", bout, 1'b1);

      // Asynchronous reset in the middle of SHIFT
      @(negedge clk);
      a = 4'hf; b = 4'h1; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_d", d, 4'h0);
      chk("t5_bout", bout, 1'b0);
      chk("t5_ready", ready, 1'b1);
      chk("t5_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("t5_no_done", seen, 0);

      for (int i = 0; i < 512; i++) begin
         ref5 = {1'b0, 4'(i >> 5)} - {1'b0, 4'(i >> 1)} - {4'b0, 1'(i)};
         run("sweep", 4'(i >> 5), 4'(i >> 1), 1'(i), ref5[3:0], ref5[4], 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
